// File: rtl/vscale_mul_div_pkg.sv
// Shared constants for the multiply/divide unit.
// Contents:
//   MD_OP_WIDTH    - width of the multiply/divide opcode (RV32M funct3)
//   md_op_e        - opcode encodings MUL..REMU
//   md_state_e     - sequencer states IDLE/MUL/DIV/DONE
//   md_in1_signed  - opcode treats rs1 as a two's-complement value
//   md_in2_signed  - opcode treats rs2 as a two's-complement value
package vscale_mul_div_pkg;

  localparam int MD_OP_WIDTH = 3;

  typedef enum logic [MD_OP_WIDTH-1:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_STATE_IDLE = 2'd0,
    MD_STATE_MUL  = 2'd1,
    MD_STATE_DIV  = 2'd2,
    MD_STATE_DONE = 2'd3
  } md_state_e;

  function automatic logic md_in1_signed(input md_op_e op);
    return (op == MD_OP_MUL) || (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
           (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  function automatic logic md_in2_signed(input md_op_e op);
    return (op == MD_OP_MUL) || (op == MD_OP_MULH) ||
           (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/vscale_mul_div_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Signals:
//   req_valid/req_ready   - request handshake (execute stage -> unit)
//   req_op                - RV32M funct3 opcode
//   req_in1/req_in2       - rs1/rs2 operands
//   kill                  - pipeline flush, aborts any request in flight
//   resp_valid/resp_ready - response handshake (unit -> writeback)
//   resp_result           - final result, zero while resp_valid is low
// Modports: master = pipeline side, slave = the unit.
interface vscale_mul_div_if #(
  parameter int XPR_LEN = 32
);
  import vscale_mul_div_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [MD_OP_WIDTH-1:0] req_op;
  logic [XPR_LEN-1:0]     req_in1;
  logic [XPR_LEN-1:0]     req_in2;
  logic                   kill;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [XPR_LEN-1:0]     resp_result;

  modport master (
    output req_valid, req_op, req_in1, req_in2, kill, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, kill, resp_ready,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/vscale_md_addsub.sv
// Adder/subtractor with carry-out shared by the multiply and divide iterations.
// Ports:
//   a_i, b_i - operands (WIDTH bits)
//   sub_i    - 1: a_i - b_i, 0: a_i + b_i
//   sum_o    - WIDTH-bit result
//   carry_o  - carry out; when subtracting, 1 means a_i >= b_i (no borrow)
module vscale_md_addsub #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] b_eff;

  // Subtraction is a + ~b + 1, so the carry-in is the sub flag itself.
  assign b_eff = sub_i ? ~b_i : b_i;
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};

endmodule

// File: rtl/vscale_mul_div.sv
// Iterative RV32M multiply/divide unit.
// One radix-2 step per cycle for 32 cycles (shift-add multiply, restoring
// divide), then one finalize cycle that applies the sign correction and
// selects the result, giving a fixed 33-cycle request-to-response latency.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   md      - request/response bundle (vscale_mul_div_if.slave)
module vscale_mul_div
  import vscale_mul_div_pkg::*;
#(
  parameter int XPR_LEN = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vscale_mul_div_if.slave       md
);

  localparam int W = XPR_LEN;
  localparam logic [4:0] ITER_LAST = 5'd31;

  md_state_e      state_q, state_d;
  md_op_e         op_q, op_d, req_op;
  logic           neg_q, neg_d;
  logic [4:0]     count_q, count_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   result_q, result_d;
  logic           resp_valid_q, resp_valid_d;

  logic           accept;
  logic           in1_neg, in2_neg, in2_zero;
  logic [W-1:0]   in1_mag, in2_mag;
  logic [W:0]     as_a, as_b, as_sum;
  logic           as_sub, as_carry;
  logic [W:0]     mul_acc;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   final_result;

  function automatic logic [W-1:0] negate(input logic [W-1:0] v);
    return ~v + W'(1);
  endfunction

  assign req_op          = md_op_e'(md.req_op);
  assign md.req_ready    = reset_n && !md.kill && (state_q == MD_STATE_IDLE);
  assign md.resp_valid   = resp_valid_q;
  assign md.resp_result  = resp_valid_q ? result_q : '0;
  assign accept          = md.req_valid && md.req_ready;

  // Operands are reduced to magnitudes on acceptance; the sign is restored at the end.
  assign in1_neg  = md_in1_signed(req_op) && md.req_in1[W-1];
  assign in2_neg  = md_in2_signed(req_op) && md.req_in2[W-1];
  assign in2_zero = (md.req_in2 == '0);
  assign in1_mag  = in1_neg ? negate(md.req_in1) : md.req_in1;
  assign in2_mag  = in2_neg ? negate(md.req_in2) : md.req_in2;

  // Multiply adds the multiplicand into the high half; divide subtracts the
  // divisor from the remainder shifted left by one quotient bit.
  always_comb begin
    as_sub = (state_q == MD_STATE_DIV);
    as_b   = {1'b0, a_q};
    if (as_sub) begin
      as_a = {hi_q, lo_q[W-1]};
    end else begin
      as_a = {1'b0, hi_q};
    end
  end

  vscale_md_addsub #(.WIDTH(W + 1)) u_addsub (
    .a_i     (as_a),
    .b_i     (as_b),
    .sub_i   (as_sub),
    .sum_o   (as_sum),
    .carry_o (as_carry)
  );

  assign mul_acc = lo_q[0] ? as_sum : {1'b0, hi_q};

  // Sign correction and result selection, evaluated once in the finalize cycle.
  // The divide-by-zero case never sets neg_q for quotients, so the all-ones
  // raw quotient and the untouched dividend come out unmodified.
  always_comb begin
    prod_fix = neg_q ? (~{hi_q, lo_q} + (2*W)'(1)) : {hi_q, lo_q};
    case (op_q)
      MD_OP_MUL:                             final_result = prod_fix[W-1:0];
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: final_result = prod_fix[2*W-1:W];
      MD_OP_DIV, MD_OP_DIVU:                 final_result = neg_q ? negate(lo_q) : lo_q;
      default:                               final_result = neg_q ? negate(hi_q) : hi_q;
    endcase
  end

  // Sequencer and datapath next state; kill overrides everything.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    neg_d        = neg_q;
    count_d      = count_q;
    a_d          = a_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      MD_STATE_IDLE: begin
        if (accept) begin
          op_d     = req_op;
          count_d  = '0;
          hi_d     = '0;
          result_d = '0;
          if (req_op[2]) begin
            a_d     = in2_mag;
            lo_d    = in1_mag;
            state_d = MD_STATE_DIV;
            if (req_op[1]) begin
              neg_d = in1_neg;
            end else begin
              neg_d = (in1_neg ^ in2_neg) && !in2_zero;
            end
          end else begin
            a_d     = in1_mag;
            lo_d    = in2_mag;
            neg_d   = in1_neg ^ in2_neg;
            state_d = MD_STATE_MUL;
          end
        end
      end
      MD_STATE_MUL: begin
        hi_d    = mul_acc[W:1];
        lo_d    = {mul_acc[0], lo_q[W-1:1]};
        count_d = count_q + 5'd1;
        if (count_q == ITER_LAST) state_d = MD_STATE_DONE;
      end
      MD_STATE_DIV: begin
        hi_d    = as_carry ? as_sum[W-1:0] : as_a[W-1:0];
        lo_d    = {lo_q[W-2:0], as_carry};
        count_d = count_q + 5'd1;
        if (count_q == ITER_LAST) state_d = MD_STATE_DONE;
      end
      MD_STATE_DONE: begin
        if (!resp_valid_q) begin
          result_d     = final_result;
          resp_valid_d = 1'b1;
        end else if (md.resp_ready) begin
          result_d     = '0;
          resp_valid_d = 1'b0;
          state_d      = MD_STATE_IDLE;
        end
      end
      default: state_d = MD_STATE_IDLE;
    endcase
    if (md.kill) begin
      state_d      = MD_STATE_IDLE;
      resp_valid_d = 1'b0;
      result_d     = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= MD_STATE_IDLE;
      op_q         <= MD_OP_MUL;
      neg_q        <= 1'b0;
      count_q      <= '0;
      a_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      count_q      <= count_d;
      a_q          <= a_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_vscale_mul_div.sv
// Directed testbench for vscale_mul_div: reset values, all multiply flavours,
// signed/unsigned divide and remainder, divide-by-zero and overflow, kill,
// reset mid-operation, and response back-pressure with a queued request.
module tb_vscale_mul_div;
  import vscale_mul_div_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  vscale_mul_div_if #(.XPR_LEN(32)) md_if ();

  vscale_mul_div #(.XPR_LEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (md_if.slave)
  );

  always #5 clk = ~clk;

  // Drive a request and wait (bounded) until the unit takes it.
  task automatic issueReq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output bit accepted);
    int waited = 0;
    accepted = 1'b0;
    md_if.req_op    = op;
    md_if.req_in1   = a;
    md_if.req_in2   = b;
    md_if.req_valid = 1'b1;
    while (!accepted && waited < 60) begin
      accepted = md_if.req_ready;
      @(posedge clk); #1;
      waited++;
    end
    md_if.req_valid = 1'b0;
  endtask

  // Count cycles from the acceptance edge until resp_valid (bounded at 40).
  task automatic waitResp(output int lat, output logic [31:0] res);
    lat = 0;
    while (!md_if.resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = md_if.resp_result;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output bit accepted, output int lat, output logic [31:0] res);
    lat = 0;
    res = '0;
    issueReq(op, a, b, accepted);
    if (accepted) waitResp(lat, res);
  endtask

  // Watch for any response over a window; used after kill / reset.
  task automatic watchNoResp(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (md_if.resp_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (md_if.req_ready !== 1'b0 || md_if.resp_valid !== 1'b0 || md_if.resp_result !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: ready=%b valid=%b result=%h, expected 0/0/00000000",
               md_if.req_ready, md_if.resp_valid, md_if.resp_result);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    checks++;
    if (md_if.req_ready !== 1'b1 || md_if.resp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: ready=%b valid=%b, expected 1/0",
               md_if.req_ready, md_if.resp_valid);
    end
    @(posedge clk); #1;
  endtask

  // Generic directed table: op, operands, hand-computed result.
  task automatic runTable(input string tag, input logic [2:0] ops[], input logic [31:0] in1s[],
                          input logic [31:0] in2s[], input logic [31:0] exps[]);
    bit acc;
    int lat;
    logic [31:0] res;
    for (int i = 0; i < ops.size(); i++) begin
      applyStimulus(ops[i], in1s[i], in2s[i], acc, lat, res);
      checks++;
      if (!acc || lat !== 33) begin
        failures++;
        $display("[TB] FAIL %s_latency[%0d]: accepted=%b latency=%0d, expected 1/33", tag, i, acc, lat);
      end
      checks++;
      if (res !== exps[i]) begin
        failures++;
        $display("[TB] FAIL %s_result[%0d]: op=%0d got %h, expected %h", tag, i, ops[i], res, exps[i]);
      end
    end
  endtask

  task automatic test_mul;
    logic [2:0]  ops[]  = '{MD_OP_MUL, MD_OP_MULHU, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MUL, MD_OP_MULH};
    logic [31:0] in1s[] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00012345, 32'h80000000};
    logic [31:0] in2s[] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h80000000};
    logic [31:0] exps[] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h23450000, 32'h40000000};
    runTable("mul", ops, in1s, in2s, exps);
  endtask

  task automatic test_div;
    logic [2:0]  ops[]  = '{MD_OP_DIV, MD_OP_REM, MD_OP_DIV, MD_OP_REM, MD_OP_DIVU, MD_OP_REMU, MD_OP_DIV, MD_OP_REM};
    logic [31:0] in1s[] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] in2s[] = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] exps[] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
    runTable("div", ops, in1s, in2s, exps);
  endtask

  task automatic test_div_zero;
    logic [2:0]  ops[]  = '{MD_OP_DIVU, MD_OP_REMU, MD_OP_DIV, MD_OP_REM};
    logic [31:0] in1s[] = '{32'd13, 32'd13, 32'hFFFFFFFB, 32'hFFFFFFFB};
    logic [31:0] in2s[] = '{32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] exps[] = '{32'hFFFFFFFF, 32'd13, 32'hFFFFFFFF, 32'hFFFFFFFB};
    runTable("divzero", ops, in1s, in2s, exps);
  endtask

  task automatic test_kill;
    bit acc, seen;
    issueReq(MD_OP_DIV, 32'd100, 32'd7, acc);
    repeat (9) begin @(posedge clk); #1; end
    md_if.kill = 1'b1;
    @(posedge clk); #1;
    md_if.kill = 1'b0;
    #1;
    checks++;
    if (!acc || md_if.resp_valid !== 1'b0 || md_if.req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL kill_abort: accepted=%b valid=%b ready=%b, expected 1/0/1",
               acc, md_if.resp_valid, md_if.req_ready);
    end
    watchNoResp(seen);
    checks++;
    if (seen) begin
      failures++;
      $display("[TB] FAIL kill_no_resp: response seen=%b, expected 0", seen);
    end
    // kill together with req_valid must not accept
    md_if.req_op    = MD_OP_MUL;
    md_if.req_in1   = 32'd3;
    md_if.req_in2   = 32'd4;
    md_if.req_valid = 1'b1;
    md_if.kill      = 1'b1;
    #1;
    checks++;
    if (md_if.req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL kill_blocks_ready: ready=%b, expected 0", md_if.req_ready);
    end
    @(posedge clk); #1;
    md_if.req_valid = 1'b0;
    md_if.kill      = 1'b0;
    #1;
    checks++;
    if (md_if.req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL kill_req_idle: ready=%b, expected 1", md_if.req_ready);
    end
    watchNoResp(seen);
    checks++;
    if (seen) begin
      failures++;
      $display("[TB] FAIL kill_req_no_resp: response seen=%b, expected 0", seen);
    end
  endtask

  task automatic test_reset_mid_mul;
    bit acc, seen;
    issueReq(MD_OP_MUL, 32'd5, 32'd5, acc);
    repeat (10) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    checks++;
    if (!acc || md_if.req_ready !== 1'b0 || md_if.resp_valid !== 1'b0 || md_if.resp_result !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_mul: accepted=%b ready=%b valid=%b result=%h, expected 1/0/0/00000000",
               acc, md_if.req_ready, md_if.resp_valid, md_if.resp_result);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if (md_if.req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_mul_ready: ready=%b, expected 1", md_if.req_ready);
    end
    watchNoResp(seen);
    checks++;
    if (seen) begin
      failures++;
      $display("[TB] FAIL reset_mid_mul_no_resp: response seen=%b, expected 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    bit acc;
    int lat;
    logic [31:0] res;
    bit held;
    md_if.resp_ready = 1'b0;
    applyStimulus(MD_OP_MUL, 32'd6, 32'd7, acc, lat, res);
    checks++;
    if (!acc || lat !== 33 || res !== 32'd42) begin
      failures++;
      $display("[TB] FAIL stall_first: accepted=%b latency=%0d result=%h, expected 1/33/0000002a",
               acc, lat, res);
    end
    // Queue the next request while the response is held
    md_if.req_op    = MD_OP_MULHU;
    md_if.req_in1   = 32'h12345678;
    md_if.req_in2   = 32'h00000010;
    md_if.req_valid = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (md_if.resp_valid !== 1'b1 || md_if.resp_result !== 32'd42 || md_if.req_ready !== 1'b0)
        held = 1'b0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("[TB] FAIL stall_hold: valid=%b result=%h ready=%b, expected 1/0000002a/0",
               md_if.resp_valid, md_if.resp_result, md_if.req_ready);
    end
    md_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (md_if.resp_valid !== 1'b0 || md_if.resp_result !== 32'h0 || md_if.req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain: valid=%b result=%h ready=%b, expected 0/00000000/1",
               md_if.resp_valid, md_if.resp_result, md_if.req_ready);
    end
    @(posedge clk); #1;
    md_if.req_valid = 1'b0;
    checks++;
    if (md_if.req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL accept_after_drain: ready=%b, expected 0 (busy)", md_if.req_ready);
    end
    waitResp(lat, res);
    checks++;
    if (lat !== 33 || res !== 32'h00000001) begin
      failures++;
      $display("[TB] FAIL queued_result: latency=%0d result=%h, expected 33/00000001", lat, res);
    end
  endtask

  initial begin
    md_if.req_valid  = 1'b0;
    md_if.req_op     = '0;
    md_if.req_in1    = '0;
    md_if.req_in2    = '0;
    md_if.kill       = 1'b0;
    md_if.resp_ready = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_kill();
    test_reset_mid_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
